bus_arbiter: RTL

Two-port arbiter that shares the single nibble-wide memory bus (12-bit address, 4-bit data, one write strobe) between the CPU (port 0) and a secondary master such as a program loader or debug port (port 1). It sits between the masters and the memory, grants one owner per tenure, and muxes address, data and write strobe onto the memory side. Read data is broadcast to both masters, with a per-port valid. A tenure timer stops one master from starving the other.

---
 rtl/bus_arbiter_pkg.sv | 7 +
 rtl/bus_arbiter_if.sv | 18 +
 rtl/bus_arbiter_tenure_timer.sv | 20 ++
 rtl/bus_arbiter.sv | 58 +++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// jimbo_bus_pkg: shared widths, arbiter state encoding and nibble type for the jimbo memory bus.
package jimbo_bus_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
    typedef logic [3:0] NIBBLE;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: both master ports plus the memory-side bus of the arbiter.
interface bus_arbiter_if #(
    parameter int ADDR_W = jimbo_bus_pkg::ADDR_W,
    parameter int DATA_W = jimbo_bus_pkg::DATA_W
);
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1, mem_addr;
    logic [DATA_W-1:0] wdata0, wdata1, mem_wdata, mem_rdata, rdata;
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_we;
    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wdata, mem_we
    );
    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/bus_arbiter_tenure_timer.sv
// tenure_timer: counts contended tenure cycles and flags the last one; TIMEOUT=0 never expires.
module tenure_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expire
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d  = clr ? '0 : inc ? cnt_q + CW'(1) : cnt_q;
        expire = (TIMEOUT != 0) && inc && (cnt_q == CW'(TIMEOUT - 1));
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: grants the memory bus to one of two masters per tenure, muxes the bus and
// pipelines per-port read valid; a tenure timer forces release when the other port waits.
module bus_arbiter
    import jimbo_bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);
    arb_state_t state_q, state_d;
    logic prio_q, prio_d, rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic own0, own1, inc, expire;
    assign own0 = state_q == OWN0;
    assign own1 = state_q == OWN1;
    assign inc  = (own0 && bus.req1) || (own1 && bus.req0);
    tenure_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .clr   (!inc),
        .expire(expire)
    );
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        rvalid0_d = own0 && !bus.we0;
        rvalid1_d = own1 && !bus.we1;
        case (state_q)
            IDLE: state_d = (bus.req0 && (!bus.req1 || !prio_q)) ? OWN0 : bus.req1 ? OWN1 : IDLE;
            OWN0: if (!bus.req0 || expire) begin
                state_d = IDLE;
                prio_d  = 1'b1;
            end
            OWN1: if (!bus.req1 || expire) begin
                state_d = IDLE;
                prio_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        state_q   <= rst ? IDLE : state_d;
        prio_q    <= rst ? 1'b0 : prio_d;
        rvalid0_q <= rst ? 1'b0 : rvalid0_d;
        rvalid1_q <= rst ? 1'b0 : rvalid1_d;
    end
    // Write strobe is gated by rst so a reset edge never coincides with a write.
    assign bus.gnt0      = own0;
    assign bus.gnt1      = own1;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_addr  = own0 ? bus.addr0 : own1 ? bus.addr1 : '0;
    assign bus.mem_wdata = own0 ? bus.wdata0 : own1 ? bus.wdata1 : '0;
    assign bus.mem_we    = ((own0 && bus.we0) || (own1 && bus.we1)) && !rst;
endmodule
